// File: rtl/nr_div_seq_ctrl.sv
// rtl/nr_div_seq_ctrl.sv - sequential non-restoring unsigned divider with valid/ready result handshake
//
// Purpose:
//    Divides an unsigned WIDTH-bit dividend by an unsigned WIDTH-bit divisor
//    using one non-restoring step per clock. The latency is fixed: WIDTH+2
//    edges from the accept edge for a nonzero divisor (the accept edge is
//    counted as the first). For a zero divisor the result is available
//    after the accept edge alone.
//
// Ports:
//    clk_i         clock, rising edge
//    rst_i         asynchronous active-high reset
//    start_i       request a division (taken only while ready_o=1)
//    dividend_i    unsigned dividend, sampled on the accept edge
//    divisor_i     unsigned divisor, sampled on the accept edge
//    ready_o       block is idle and can accept start_i
//    out_valid_o   quo_o/rem_o/div_zero_o hold a result
//    out_ready_i   consumer takes the result
//    quo_o         unsigned quotient (all ones on divide by zero)
//    rem_o         unsigned remainder (dividend on divide by zero)
//    div_zero_o    accepted divisor was zero

module nr_div_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             ready_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             div_zero_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_CORRECT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;       // partial remainder, two's complement
   logic [WIDTH-1:0] q_q, q_d;       // dividend bits shift out the top, quotient bits shift in the bottom
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   dvs_ext;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   a_step;
   logic [WIDTH:0]   a_fix;
   logic             last_step;

   // The shifted value may wrap in WIDTH+1 bits, but the add/subtract
   // result always lies in [-divisor, divisor), so modular arithmetic
   // lands on the correct value.
   assign dvs_ext   = {1'b0, dvs_q};
   assign a_shift   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign a_step    = a_q[WIDTH] ? (a_shift + dvs_ext) : (a_shift - dvs_ext);
   assign a_fix     = a_q + dvs_ext;
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d   = '0;
               q_d   = dividend_i;
               dvs_d = divisor_i;
               cnt_d = '0;
               if (divisor_i == '0) begin
                  // Divide by zero skips the iteration entirely.
                  quo_d   = '1;
                  rem_d   = dividend_i;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            a_d   = a_step;
            q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
               state_d = S_CORRECT;
            end
         end

         S_CORRECT: begin
            // A negative final remainder is restored by one add-back.
            if (a_q[WIDTH]) begin
               a_d   = a_fix;
               rem_d = a_fix[WIDTH-1:0];
            end else begin
               rem_d = a_q[WIDTH-1:0];
            end
            quo_d   = q_q;
            dz_d    = 1'b0;
            state_d = S_DONE;
         end

         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ready_o     = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign quo_o       = quo_q;
   assign rem_o       = rem_q;
   assign div_zero_o  = dz_q;

endmodule

// File: doc/nr_div_seq_ctrl.md
NR_DIV_SEQ_CTRL -- requirements
Module: nr_div_seq_ctrl

Interface
REQ-001: Parameter WIDTH, default 16: operand, quotient and remainder width in bits, minimum 2.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: start  input  1  request to begin a division; accepted only when ready=1.
REQ-005: dividend  input  WIDTH  unsigned dividend; sampled on the accept edge.
REQ-006: divisor  input  WIDTH  unsigned divisor; sampled on the accept edge.
REQ-007: ready  output  1  high only in IDLE; the block can accept start.
REQ-008: out_valid  output  1  high only in DONE; quo, rem and div_zero are valid.
REQ-009: out_ready  input  1  consumer acceptance of the result.
REQ-010: quo  output  WIDTH  unsigned quotient.
REQ-011: rem  output  WIDTH  unsigned remainder, always below the divisor when div_zero=0.
REQ-012: div_zero  output  1  the accepted divisor was zero.

Function
REQ-013: The block SHALL implement a four-state FSM: IDLE, RUN, CORRECT, DONE.
REQ-014: Accept edge: a rising edge with state=IDLE and start=1; it SHALL latch dividend and divisor and clear the partial remainder A to 0.
REQ-015: A SHALL be WIDTH+1 bits two's complement; the quotient shift register SHALL be WIDTH bits; the step counter SHALL be clog2(WIDTH+1) bits.
REQ-016: IDLE->RUN on accept when divisor!=0; IDLE->DONE on accept when divisor==0.
REQ-017: In RUN, each edge SHALL perform one non-restoring step, MSB of the dividend first.
- Shift: A <= {A[WIDTH-1:0], next dividend bit}.
- Then add the divisor if A was negative before the shift; otherwise subtract it.
- Shift in ~sign(new A) as the quotient LSB.
REQ-018: RUN SHALL last exactly WIDTH edges, then move to CORRECT.
REQ-019: CORRECT SHALL take exactly one edge.
- If A is negative: A <= A + divisor.
- Either way, go to DONE.
- The latency is fixed and does not depend on the data.
REQ-020: out_valid SHALL rise exactly WIDTH+2 edges after the accept edge for a nonzero divisor, and 1 edge after it for a zero divisor.
REQ-021: A zero divisor SHALL give quo={WIDTH{1'b1}}, rem=dividend, div_zero=1; no RUN cycles are spent.
REQ-022: In DONE, quo, rem and div_zero SHALL hold stable while out_ready=0, with no timeout.
REQ-023: DONE->IDLE on the edge where out_ready=1. ready SHALL be 1 on the following cycle; a new start is never accepted in the handshake cycle.
REQ-024: start SHALL be ignored outside IDLE; dividend and divisor changes outside the accept edge SHALL have no effect.
REQ-025: quo, rem and div_zero SHALL keep their last values in IDLE until the next result is loaded into DONE.
REQ-026: out_ready outside DONE SHALL be ignored.
REQ-027: All arithmetic SHALL be unsigned on operands; results SHALL be exact for every WIDTH-bit pair, including dividend<divisor (quo=0, rem=dividend) and divisor=1.

Reset
REQ-028: While rst=1, independent of clk: state=IDLE, ready=1, out_valid=0, quo=0, rem=0, div_zero=0, and A, counter and operand registers = 0.
REQ-029: A reset asserted in RUN, CORRECT or DONE SHALL abort the operation and discard its result; the first edge after rst deasserts may accept a new start.

Verification
REQ-030: V1: 90/33, out_ready=1. Required: out_valid exactly 18 edges after the accept edge, quo=2, rem=24, div_zero=0.
REQ-031: V2: 901/300, then 7/9, then 65535/1. Required: (3,1), (0,7), (65535,0).
REQ-032: V3: 5/0. Required: out_valid 1 edge after accept, quo=16'hFFFF, rem=5, div_zero=1.
REQ-033: V4: 1000/7 with out_ready=0 for 10 cycles. Required: quo=142, rem=6, both stable throughout; ready=0 until 1 cycle after the out_ready=1 edge; start pulses during busy are ignored.
REQ-034: V5: rst pulsed mid-RUN (step 5 of 100/3). Required: immediate return to the reset values; a following 100/3 gives quo=33, rem=1.
REQ-035: V6: 2000 random operand pairs, including 0, 1 and 16'hFFFF, against a reference model. Required: zero mismatches; latency always 18 edges (1 edge for a zero divisor).
